pe_inst_seq: RTL and testbench
==============================

Name: pe_inst_seq

Overview:
- Instruction sequencer for one PE's DSP control decoder.
- Holds a small program of {opcode, repeat} words and issues opcode/inst_v pairs to the decoder at one per cycle, with no bubbles between words.
- Waits for the decoder's 6-stage result pipeline to drain, then signals done.
- Sits between the array-level host/loader and the per-PE decoder.

Parameters:
- PROG_DEPTH, 16, number of program words (power of 2).
- AW, 4, program address width (log2 PROG_DEPTH).
- RPT_W, 8, repeat-count field width.
- DRAIN_CYC, 6, cycles after the last issue before done; matches the decoder output-valid pipeline depth.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- prog_we  in  1  program write strobe.
- prog_addr  in  AW  program write address.
- prog_wdata  in  3+RPT_W  word: [RPT_W+2:RPT_W]=opcode, [RPT_W-1:0]=repeat.
- prog_last  in  AW  index of the last valid program word; sampled on start.
- start  in  1  single-cycle run request.
- stall  in  1  hold issue (downstream back-pressure).
- inst_v  out  1  instruction valid to decoder.
- opcode  out  3  opcode to decoder.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle pulse at the end of the drain.

Behaviour:
- Reset (async, rst_n=0): inst_v=0, opcode=3'b000, busy=0, done=0, state=IDLE, all counters 0. Program memory contents are not reset.
- Program memory is synchronous-write; a write with prog_we=1 while busy=1 is ignored.
- Word semantics: repeat=R means R+1 consecutive issues of that opcode, so R=0 gives one issue and R=255 gives 256.
- FSM states: IDLE, FETCH, RUN, DRAIN.
- IDLE: start=1 latches prog_last, sets addr=0 and busy=1, and moves to FETCH. A start while not in IDLE is ignored.
- FETCH: one cycle of synchronous read of word 0, then RUN. The first inst_v=1 appears in the 2nd cycle after the start cycle.
- RUN, each cycle with stall=0:
  - drive inst_v=1 and opcode=word.opcode;
  - decrement the repeat counter;
  - when the counter reaches 0, advance addr.
  - The next word is prefetched during the last repeat, so consecutive words issue back-to-back with no gap.
- RUN, each cycle with stall=1: inst_v=0, opcode holds its value, and counters and addr are frozen. Stall has no effect in IDLE, FETCH or DRAIN.
- Last issue of word prog_last: next state is DRAIN, with the drain counter loaded to DRAIN_CYC-1.
- DRAIN: inst_v=0 and opcode=3'b000 (LOAD/no-op). Counts down; at 0, done=1 for one cycle, busy=0, then IDLE.
- Total cycles from start to done with no stall: 2 + Σ(R_i+1) + DRAIN_CYC.
- Boundaries:
  - prog_last=0 runs a single word.
  - prog_last=PROG_DEPTH-1 runs the whole memory; addr wrap is never reached.
  - start coincident with done: start is ignored (state is still DRAIN).
  - rst_n deasserted mid-RUN: immediate return to IDLE with outputs at reset values; no done pulse.

Optional Feature:
- Macro PE_INST_SEQ_LOOP_EN.
- When defined:
  - adds input loop_cnt [7:0], sampled on start;
  - after word prog_last, jumps back to addr 0 (no FETCH bubble; prefetch from 0) for loop_cnt additional passes before DRAIN;
  - loop_cnt=0 behaves as no loop.
- When undefined: no port is added and the program runs exactly once.

Decomposition:
- Shared package parameters.vh holds:
  - opcode constants OP_LOAD=000, ADD=001, SUB=010, MUL=100, MULADD=101, MULSUB=110, MAX=111;
  - the instruction-word field offsets;
  - DRAIN_CYC default.
- One sub-module: pe_prog_mem (PROG_DEPTH x (3+RPT_W) sync-write/sync-read memory, inferable as distributed RAM).
- FSM and counters live in the top module.

Test Plan:
- Reset check: hold rst_n=0 → inst_v=0, opcode=000, busy=0, done=0. Release reset, then start with prog_last=0 and word {MUL, R=0} → inst_v high for exactly 1 cycle with opcode=100 (2 cycles after start); done exactly 7 cycles after that issue.
- Program {ADD,R=2},{SUB,R=0},{MULADD,R=1}, prog_last=2 → inst_v high for 6 contiguous cycles with opcodes 001,001,001,010,101,101; done at start+2+6+6.
- Same program with stall=1 for 2 cycles during the 2nd ADD → exactly 2 inst_v=0 cycles inserted; opcode held at 001; sequence otherwise unchanged; done delayed by 2.
- prog_we and start asserted while busy → memory contents and the run are unaffected (readback via rerun matches the original).
- rst_n pulsed low mid-RUN → outputs reset immediately, no done pulse; a following start runs the full program from word 0.
- PE_INST_SEQ_LOOP_EN defined: loop_cnt=2 with program {MAX,R=0},{ADD,R=0} → opcodes 111,001 ×3 back-to-back (6 issues), then done after 6 drain cycles.

Source files
------------

// File: rtl/pe_inst_seq_pkg.sv
// Shared definitions for the PE instruction sequencer: opcodes, word layout,
// default sizes and the sequencer state encoding.
package pe_inst_seq_pkg;

    localparam int OP_W = 3;

    localparam logic [2:0] OP_LOAD   = 3'b000;
    localparam logic [2:0] OP_ADD    = 3'b001;
    localparam logic [2:0] OP_SUB    = 3'b010;
    localparam logic [2:0] OP_MUL    = 3'b100;
    localparam logic [2:0] OP_MULADD = 3'b101;
    localparam logic [2:0] OP_MULSUB = 3'b110;
    localparam logic [2:0] OP_MAX    = 3'b111;

    localparam int PROG_DEPTH_DEF = 16;
    localparam int AW_DEF         = 4;
    localparam int RPT_W_DEF      = 8;
    localparam int DRAIN_CYC_DEF  = 6;

    // Instruction word is {opcode, repeat}; repeat occupies the low bits.
    localparam int RPT_LSB = 0;

    function automatic int op_lsb(input int rpt_w);
        return rpt_w;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/pe_prog_mem.sv
// Program store: synchronous write, registered read, no reset so it maps onto
// distributed RAM.
module pe_prog_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = 11
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/pe_inst_seq.sv
// Instruction sequencer for one PE decoder: issues {opcode, repeat} words
// back-to-back, drains the decoder pipeline, then pulses done.
// Optional macro PE_INST_SEQ_LOOP_EN adds loop_cnt for repeated program passes.
module pe_inst_seq
    import pe_inst_seq_pkg::*;
#(
    parameter int PROG_DEPTH = PROG_DEPTH_DEF,
    parameter int AW         = AW_DEF,
    parameter int RPT_W      = RPT_W_DEF,
    parameter int DRAIN_CYC  = DRAIN_CYC_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             prog_we,
    input  logic [AW-1:0]    prog_addr,
    input  logic [RPT_W+2:0] prog_wdata,
    input  logic [AW-1:0]    prog_last,
    input  logic             start,
    input  logic             stall,
`ifdef PE_INST_SEQ_LOOP_EN
    input  logic [7:0]       loop_cnt,
`endif
    output logic             inst_v,
    output logic [2:0]       opcode,
    output logic             busy,
    output logic             done
);

    localparam int WW     = OP_W + RPT_W;
    localparam int OP_LSB = op_lsb(RPT_W);
    localparam int DCW    = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DCW-1:0] DRAIN_LOAD = DCW'(DRAIN_CYC - 1);

    state_t           state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [AW-1:0]    last_q, last_d;
    logic [RPT_W-1:0] cnt_q, cnt_d;
    logic [DCW-1:0]   drain_q, drain_d;
    logic             done_q, done_d;
    logic             wrap;

    logic [WW-1:0]    word;
    logic [2:0]       word_op;
    logic [RPT_W-1:0] word_rpt;
    logic             mem_we;

`ifdef PE_INST_SEQ_LOOP_EN
    logic [7:0]       loop_q, loop_d;
    assign wrap = (loop_q != 8'd0);
`else
    assign wrap = 1'b0;
`endif

    assign word_op  = word[WW-1:OP_LSB];
    assign word_rpt = word[RPT_LSB +: RPT_W];
    assign mem_we   = prog_we && (state_q == ST_IDLE);

    // Read address follows the next-state address, so the word needed in the
    // following cycle is already registered at the memory output.
    pe_prog_mem #(
        .DEPTH (PROG_DEPTH),
        .AW    (AW),
        .DW    (WW)
    ) u_prog_mem (
        .clk_i   (clk),
        .we_i    (mem_we),
        .waddr_i (prog_addr),
        .wdata_i (prog_wdata),
        .raddr_i (addr_d),
        .rdata_o (word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            last_q  <= '0;
            cnt_q   <= '0;
            drain_q <= '0;
            done_q  <= 1'b0;
`ifdef PE_INST_SEQ_LOOP_EN
            loop_q  <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
            done_q  <= done_d;
`ifdef PE_INST_SEQ_LOOP_EN
            loop_q  <= loop_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        drain_d = drain_q;
        done_d  = 1'b0;
`ifdef PE_INST_SEQ_LOOP_EN
        loop_d  = loop_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    last_d  = prog_last;
                    addr_d  = '0;
                    cnt_d   = '0;
                    state_d = ST_FETCH;
`ifdef PE_INST_SEQ_LOOP_EN
                    loop_d  = loop_cnt;
`endif
                end
            end
            ST_FETCH: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!stall) begin
                    if (cnt_q == word_rpt) begin
                        cnt_d = '0;
                        if (addr_q != last_q) begin
                            addr_d = addr_q + AW'(1);
                        end else if (wrap) begin
                            addr_d = '0;
`ifdef PE_INST_SEQ_LOOP_EN
                            loop_d = loop_q - 8'd1;
`endif
                        end else begin
                            state_d = ST_DRAIN;
                            drain_d = DRAIN_LOAD;
                        end
                    end else begin
                        cnt_d = cnt_q + RPT_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                // done is raised while still in DRAIN so a start in that cycle is ignored.
                if (drain_q != '0) begin
                    drain_d = drain_q - DCW'(1);
                end else if (!done_q) begin
                    done_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        inst_v = 1'b0;
        opcode = OP_LOAD;
        busy   = (state_q != ST_IDLE);
        done   = done_q;
        if (state_q == ST_RUN) begin
            opcode = word_op;
            inst_v = !stall;
        end
    end

endmodule

// File: tb/tb_pe_inst_seq.sv
// Scoreboard bench for pe_inst_seq: directed programs push expected issues and
// done pulses; a negedge monitor pops and compares every DUT output event.
module tb_pe_inst_seq;
    import pe_inst_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        prog_we = 1'b0;
    logic [3:0]  prog_addr = '0;
    logic [10:0] prog_wdata = '0;
    logic [3:0]  prog_last = '0;
    logic        start = 1'b0;
    logic        stall = 1'b0;
`ifdef PE_INST_SEQ_LOOP_EN
    logic [7:0]  loop_cnt = '0;
`endif
    logic        inst_v;
    logic [2:0]  opcode;
    logic        busy;
    logic        done;

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int done_seen = 0;

    logic [2:0] prog_op [16];
    int         prog_rpt [16];

    typedef struct {
        bit         is_done;
        logic [2:0] op;
        int         cyc;
    } exp_t;
    exp_t sb_q[$];

    pe_inst_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_wdata (prog_wdata),
        .prog_last  (prog_last),
        .start      (start),
        .stall      (stall),
`ifdef PE_INST_SEQ_LOOP_EN
        .loop_cnt   (loop_cnt),
`endif
        .inst_v     (inst_v),
        .opcode     (opcode),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic see(input bit is_done, input logic [2:0] op);
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event actual_done=%0d actual_op=%0d required=none (cycle %0d)",
                     is_done, op, cyc);
        end else begin
            e = sb_q.pop_front();
            chk("event_kind", int'(is_done), int'(e.is_done));
            chk("event_opcode", int'(op), int'(e.op));
            chk("event_cycle", cyc, e.cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (inst_v) see(1'b0, opcode);
            if (done) begin
                done_seen++;
                see(1'b1, opcode);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [2:0] op, input int r);
        prog_we    = 1'b1;
        prog_addr  = 4'(a);
        prog_wdata = {op, 8'(r)};
        prog_op[a]  = op;
        prog_rpt[a] = r;
        tick();
        prog_we = 1'b0;
    endtask

    // Stall window and abort point are offsets from the start cycle (0 = none).
    task automatic run(input int last, input int lp, input int st_off, input int st_len,
                       input logic [2:0] st_op, input bit poke, input int abort_off);
        int   c, t, done_off, d0;
        exp_t e;
        c = cyc;
        t = c + 2;
        for (int p = 0; p <= lp; p++) begin
            for (int w = 0; w <= last; w++) begin
                for (int r = 0; r <= prog_rpt[w]; r++) begin
                    while (t - c >= st_off && t - c < st_off + st_len) t++;
                    if (abort_off == 0 || t - c < abort_off) begin
                        e.is_done = 1'b0;
                        e.op      = prog_op[w];
                        e.cyc     = t;
                        sb_q.push_back(e);
                    end
                    t++;
                end
            end
        end
        done_off = t + 6 - c;
        if (abort_off == 0) begin
            e.is_done = 1'b1;
            e.op      = OP_LOAD;
            e.cyc     = t + 6;
            sb_q.push_back(e);
        end
        prog_last = 4'(last);
`ifdef PE_INST_SEQ_LOOP_EN
        loop_cnt = 8'(lp);
`endif
        d0 = done_seen;
        start = 1'b1;
        for (int k = 1; k < 1200; k++) begin
            tick();
            start   = 1'b0;
            prog_we = 1'b0;
            stall   = (k >= st_off && k < st_off + st_len);
            if (stall) begin
                #1;
                chk("stall_inst_v", int'(inst_v), 0);
                chk("stall_opcode", int'(opcode), int'(st_op));
            end
            if (poke && k == 3) begin
                prog_we    = 1'b1;
                prog_addr  = 4'd0;
                prog_wdata = {OP_MAX, 8'd5};
                start      = 1'b1;
            end
            if (poke && k == done_off) start = 1'b1;
            if (abort_off != 0 && k == abort_off) begin
                rst_n = 1'b0;
                #1;
                chk("abort_inst_v", int'(inst_v), 0);
                chk("abort_opcode", int'(opcode), 0);
                chk("abort_busy", int'(busy), 0);
                chk("abort_done", int'(done), 0);
                tick();
                tick();
                rst_n = 1'b1;
                break;
            end
            if (done_seen != d0) break;
        end
        if (abort_off == 0 && done_seen == d0) chk("done_timeout", 0, 1);
        stall = 1'b0;
        repeat (3) tick();
        chk("busy_after_run", int'(busy), 0);
        chk("scoreboard_empty", sb_q.size(), 0);
        sb_q.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) tick();
        chk("reset_inst_v", int'(inst_v), 0);
        chk("reset_opcode", int'(opcode), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        rst_n = 1'b1;
        tick();

        // Single word, prog_last = 0
        wr(0, OP_MUL, 0);
        run(0, 0, 0, 0, OP_LOAD, 1'b0, 0);

        // Three-word program, no stall
        wr(0, OP_ADD, 2);
        wr(1, OP_SUB, 0);
        wr(2, OP_MULADD, 1);
        run(2, 0, 0, 0, OP_LOAD, 1'b0, 0);

        // Two stall cycles during the second ADD
        run(2, 0, 3, 2, OP_ADD, 1'b0, 0);

        // Write and start while busy, start on the done cycle; then rerun
        run(2, 0, 0, 0, OP_LOAD, 1'b1, 0);
        run(2, 0, 0, 0, OP_LOAD, 1'b0, 0);

        // Reset mid-RUN, then a full run from word 0
        run(2, 0, 0, 0, OP_LOAD, 1'b0, 4);
        run(2, 0, 0, 0, OP_LOAD, 1'b0, 0);

        // Whole memory, last word with the maximum repeat count
        for (int i = 0; i < 15; i++) wr(i, 3'(i), i % 3);
        wr(15, OP_MULSUB, 255);
        run(15, 0, 0, 0, OP_LOAD, 1'b0, 0);

`ifdef PE_INST_SEQ_LOOP_EN
        wr(0, OP_MAX, 0);
        wr(1, OP_ADD, 0);
        run(1, 2, 0, 0, OP_LOAD, 1'b0, 0);
        run(1, 0, 0, 0, OP_LOAD, 1'b0, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
